// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// master: byte source that also observes the memory write port.
// slave:  the loader, which consumes bytes and drives the memory writes.
interface prog_loader_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses SYNC/LEN/words/CSUM frames from a byte stream,
// writes 16-bit words into instruction memory and holds the CPU in reset
// while a frame is in flight. All outputs are registered.
module prog_loader #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            loading,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       state;
  logic [2:0]       nextState;
  logic [ADDR_W:0]  lenN;
  logic [7:0]       hiByte;
  logic [7:0]       csum;
  logic [CNT_W-1:0] toCnt;

  logic xfer;
  logic syncAccept;
  logic lenBad;
  logic timed;
  logic timeoutHit;

  assign xfer       = bus.in_valid && bus.in_ready;
  assign syncAccept = xfer && (bus.in_data == SYNC_BYTE) &&
                      ((state == S_IDLE) || (state == S_ERR));
  assign lenBad     = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH);
  assign timed      = (state == S_LEN) || (state == S_HI) ||
                      (state == S_LO)  || (state == S_CSUM);
  // The byte arriving on the last allowed cycle still wins over the timeout.
  assign timeoutHit = timed && !xfer && (toCnt == TO_LAST);

  // Frame parser next-state decision.
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE, S_ERR: if (syncAccept) nextState = S_LEN;
      S_LEN:         if (xfer) nextState = lenBad ? S_ERR : S_HI;
      S_HI:          if (xfer) nextState = S_LO;
      S_LO:          if (xfer) nextState = S_WRITE;
      S_WRITE:       nextState = ((words_loaded + 1'b1) < lenN) ? S_HI : S_CSUM;
      S_CSUM:        if (xfer) nextState = (bus.in_data == csum) ? S_IDLE : S_ERR;
      default:       nextState = S_IDLE;
    endcase
    if (timeoutHit) nextState = S_ERR;
  end

  // Control state and registered outputs; reset forces the CPU into reset
  // and kills any in-flight memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_rst        <= 1'b1;
      loading        <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      toCnt          <= '0;
    end else begin
      state        <= nextState;
      bus.in_ready <= (nextState != S_WRITE);
      bus.imem_we  <= (nextState == S_WRITE);
      // CPU only runs while idling; leaving CSUM keeps it held one more cycle.
      cpu_rst      <= !((state == S_IDLE) && (nextState == S_IDLE));

      if ((state == S_LO) && xfer) begin
        bus.imem_addr  <= words_loaded[ADDR_W-1:0];
        bus.imem_wdata <= {hiByte, bus.in_data};
      end

      if (syncAccept) begin
        words_loaded <= '0;
        loading      <= 1'b1;
        error        <= 1'b0;
      end else begin
        if (state == S_WRITE) words_loaded <= words_loaded + 1'b1;
        if ((nextState == S_ERR) || ((state == S_CSUM) && (nextState == S_IDLE)))
          loading <= 1'b0;
        if ((nextState == S_ERR) && (state != S_ERR)) error <= 1'b1;
      end

      if (timed && !xfer && (nextState == state)) toCnt <= toCnt + 1'b1;
      else                                        toCnt <= '0;
    end
  end

  // Frame datapath: length, high byte and running checksum.
  always_ff @(posedge clk) begin
    if (syncAccept) csum <= 8'd0;
    else if (xfer && ((state == S_LEN) || (state == S_HI) || (state == S_LO)))
      csum <= csum ^ bus.in_data;
    if ((state == S_LEN) && xfer) lenN <= (ADDR_W + 1)'(bus.in_data);
    if ((state == S_HI) && xfer)  hiByte <= bus.in_data;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frame table, hand-written multi-cycle
// sequences (full image, timeout boundary, reset mid-write) and randomized
// frames checked against a frame-level reference parser.
module tb_prog_loader;

  localparam int         AW    = 7;
  localparam int         DEPTH = 2 ** AW;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         TOC   = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wrec_t;

  typedef struct {
    int          nb;
    logic [63:0] stim;
    int          expW;
    int          expLastAddr;
    logic [15:0] expLastData;
    logic        expErr;
    int          expWl;
    logic        expCpuRst;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        cpu_rst;
  logic        loading;
  logic        error;
  logic [AW:0] words_loaded;

  prog_loader_if #(.ADDR_W(AW)) bus();

  prog_loader #(.ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TOC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cpu_rst      (cpu_rst),
    .loading      (loading),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] stimQ[$];
  wrec_t      expQ[$];
  wrec_t      obsQ[$];
  logic       mErr;
  int         mWl;
  vec_t       vec[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Record every memory write; the loader must not accept bytes during one.
  always @(negedge clk) begin
    if (!rst && bus.imem_we) begin
      wrec_t r;
      r.addr = bus.imem_addr;
      r.data = bus.imem_wdata;
      obsQ.push_back(r);
      chk("ready_low_on_write", {31'd0, bus.in_ready}, 32'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high byte=%0h", b);
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Frame-level reference: walks the byte list by the framing rules.
  task automatic modelRun();
    int i;
    int n;
    logic [7:0] cs;
    wrec_t r;
    expQ.delete();
    i = 0;
    while (i < stimQ.size()) begin
      if (stimQ[i] != SYNC) begin
        i++;
      end else begin
        mErr = 1'b0;
        mWl  = 0;
        i++;
        n  = int'(stimQ[i]);
        cs = stimQ[i];
        i++;
        if (n == 0 || n > DEPTH) begin
          mErr = 1'b1;
        end else begin
          for (int k = 0; k < n; k++) begin
            r.addr = AW'(k);
            r.data = {stimQ[i], stimQ[i+1]};
            cs = cs ^ stimQ[i] ^ stimQ[i+1];
            i += 2;
            expQ.push_back(r);
            mWl = k + 1;
          end
          if (stimQ[i] != cs) mErr = 1'b1;
          i++;
        end
      end
    end
  endtask

  // kind 0: good frame, 1: bad checksum, 2: bad length.
  task automatic buildStream(input int kind, input int forceN);
    logic [7:0] b;
    logic [7:0] cs;
    int n;
    stimQ.delete();
    repeat ($urandom_range(0, 3)) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      stimQ.push_back(b);
    end
    stimQ.push_back(SYNC);
    if (kind == 2) begin
      if ($urandom_range(0, 1) == 1) stimQ.push_back(8'h00);
      else stimQ.push_back(8'($urandom_range(DEPTH + 1, 255)));
    end else begin
      n = (forceN > 0) ? forceN : $urandom_range(1, 8);
      stimQ.push_back(8'(n));
      cs = 8'(n);
      for (int k = 0; k < 2 * n; k++) begin
        b = 8'($urandom_range(0, 255));
        stimQ.push_back(b);
        cs ^= b;
      end
      if (kind == 1) cs ^= 8'($urandom_range(1, 255));
      stimQ.push_back(cs);
    end
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h01;
      stimQ.push_back(b);
    end
  endtask

  task automatic runAndCompare(input string tag, input int maxGap);
    modelRun();
    obsQ.delete();
    foreach (stimQ[j]) sendByte(stimQ[j], $urandom_range(0, maxGap));
    idle(3);
    chk({tag, "_nwrites"}, obsQ.size(), expQ.size());
    for (int k = 0; k < expQ.size() && k < obsQ.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), {8'd0, obsQ[k]}, {8'd0, expQ[k]});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, mErr});
    chk({tag, "_words"}, words_loaded, mWl);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, mErr});
    chk({tag, "_loading"}, {31'd0, loading}, 32'd0);
  endtask

  initial begin
    vec[0] = '{1, 64'h12, 0, 0, 16'h0, 1'b0, 0, 1'b0};
    vec[1] = '{7, 64'h0042CDAB341202A5, 2, 1, 16'hABCD, 1'b0, 2, 1'b0};
    vec[2] = '{7, 64'h0043CDAB341202A5, 2, 1, 16'hABCD, 1'b1, 2, 1'b1};
    vec[3] = '{2, 64'h00A5, 0, 0, 16'h0, 1'b1, 0, 1'b1};
    vec[4] = '{2, 64'h81A5, 0, 0, 16'h0, 1'b1, 0, 1'b1};
    vec[5] = '{5, 64'hFE5AA501A5, 1, 0, 16'hA55A, 1'b0, 1, 1'b0};
    vec[6] = '{7, 64'h01000001A53412, 1, 0, 16'h0000, 1'b0, 1, 1'b0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    idle(2);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", {25'd0, bus.imem_addr}, 32'd0);
    chk("rst_imem_wdata", {16'd0, bus.imem_wdata}, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_loading", {31'd0, loading}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_words", words_loaded, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rel_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      obsQ.delete();
      for (int j = 0; j < vec[v].nb; j++) sendByte(vec[v].stim[8*j +: 8], 0);
      idle(3);
      chk($sformatf("v%0d_nwrites", v), obsQ.size(), vec[v].expW);
      if (vec[v].expW > 0 && obsQ.size() > 0) begin
        chk($sformatf("v%0d_last_addr", v), {25'd0, obsQ[$].addr}, vec[v].expLastAddr);
        chk($sformatf("v%0d_last_data", v), {16'd0, obsQ[$].data}, {16'd0, vec[v].expLastData});
      end
      chk($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vec[v].expErr});
      chk($sformatf("v%0d_words", v), words_loaded, vec[v].expWl);
      chk($sformatf("v%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, vec[v].expCpuRst});
      chk($sformatf("v%0d_loading", v), {31'd0, loading}, 32'd0);
    end

    // Full image filling every memory word.
    mErr = 1'b0;
    mWl  = 0;
    buildStream(0, DEPTH);
    runAndCompare("full", 1);
    if (obsQ.size() > 0) chk("full_last_addr", {25'd0, obsQ[$].addr}, DEPTH - 1);
    chk("full_words", words_loaded, DEPTH);

    for (int it = 0; it < 20; it++) begin
      buildStream($urandom_range(0, 2), 0);
      runAndCompare($sformatf("rnd%0d", it), 2);
    end

    // Timeout boundary: 15 idle cycles are tolerated, the 16th aborts.
    obsQ.delete();
    sendByte(SYNC, 0);
    chk("to_loading", {31'd0, loading}, 32'd1);
    chk("to_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    idle(TOC - 1);
    chk("to_before_err", {31'd0, error}, 32'd0);
    idle(1);
    chk("to_err", {31'd0, error}, 32'd1);
    chk("to_err_loading", {31'd0, loading}, 32'd0);
    chk("to_nwrites", obsQ.size(), 32'd0);

    obsQ.delete();
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    idle(TOC - 1);
    sendByte(8'h34, 0);
    sendByte(8'h27, 0);
    idle(3);
    chk("to_ok_error", {31'd0, error}, 32'd0);
    chk("to_ok_nwrites", obsQ.size(), 32'd1);
    if (obsQ.size() > 0) chk("to_ok_data", {16'd0, obsQ[0].data}, 32'h1234);
    chk("to_ok_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Reset asserted in the middle of a write cycle.
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    sendByte(8'h34, 0);
    chk("mw_we_before", {31'd0, bus.imem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mw_we", {31'd0, bus.imem_we}, 32'd0);
    chk("mw_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mw_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("mw_loading", {31'd0, loading}, 32'd0);
    chk("mw_words", words_loaded, 32'd0);
    chk("mw_addr", {25'd0, bus.imem_addr}, 32'd0);
    chk("mw_wdata", {16'd0, bus.imem_wdata}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    obsQ.delete();
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'hBE, 0);
    sendByte(8'hEF, 0);
    sendByte(8'h50, 0);
    idle(3);
    chk("mw_re_nwrites", obsQ.size(), 32'd1);
    if (obsQ.size() > 0) begin
      chk("mw_re_addr", {25'd0, obsQ[0].addr}, 32'd0);
      chk("mw_re_data", {16'd0, obsQ[0].data}, 32'hBEEF);
    end
    chk("mw_re_error", {31'd0, error}, 32'd0);
    chk("mw_re_words", words_loaded, 32'd1);
    chk("mw_re_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
